// File: rtl/cache_refill_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cache_refill_ctrl_pkg
// Shared definitions for the cache miss/refill sequencer:
//   - default address / data widths
//   - FSM state encoding (IDLE=0, IRD=1, DRD=2, DWR=3, IFILL=4, DFILL=5)
// ----------------------------------------------------------------------------
package cache_refill_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIrd   = 3'd1,
        StDrd   = 3'd2,
        StDwr   = 3'd3,
        StIfill = 3'd4,
        StDfill = 3'd5
    } state_e;

endpackage

// File: rtl/cache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// cache_refill_ctrl
// Miss/refill sequencer sharing one single-word memory port between the
// instruction cache and the write-through data cache.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_ifetch/i_iaddr/i_ihit       core fetch request and icache hit
//   i_dload/i_dstore/i_daddr/
//   i_dwdata/i_dhit               core load/store request and dcache hit
//   o_ifill_wen/addr/data         icache fill port (one-cycle pulse)
//   o_dfill_wen/addr/data         dcache fill port (one-cycle pulse)
//   o_stall                       core stall (combinational)
//   o_mreq/o_mwe/o_maddr/o_mwdata memory request, registered and held
//   i_mack/i_mrdata               memory acknowledge and read data
// ----------------------------------------------------------------------------
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ifetch,
    input  logic [ADDR_W-1:0] i_iaddr,
    input  logic              i_ihit,
    input  logic              i_dload,
    input  logic              i_dstore,
    input  logic [ADDR_W-1:0] i_daddr,
    input  logic [DATA_W-1:0] i_dwdata,
    input  logic              i_dhit,
    output logic              o_ifill_wen,
    output logic [ADDR_W-1:0] o_ifill_addr,
    output logic [DATA_W-1:0] o_ifill_data,
    output logic              o_dfill_wen,
    output logic [ADDR_W-1:0] o_dfill_addr,
    output logic [DATA_W-1:0] o_dfill_data,
    output logic              o_stall,
    output logic              o_mreq,
    output logic              o_mwe,
    output logic [ADDR_W-1:0] o_maddr,
    output logic [DATA_W-1:0] o_mwdata,
    input  logic              i_mack,
    input  logic [DATA_W-1:0] i_mrdata
);

    state_e            r_state;
    logic              r_sdone;
    logic              r_mreq;
    logic              r_mwe;
    logic [ADDR_W-1:0] r_maddr;
    logic [DATA_W-1:0] r_mwdata;
    logic              r_ifill_wen;
    logic [ADDR_W-1:0] r_ifill_addr;
    logic [DATA_W-1:0] r_ifill_data;
    logic              r_dfill_wen;
    logic [ADDR_W-1:0] r_dfill_addr;
    logic [DATA_W-1:0] r_dfill_data;

    logic w_store_req;
    logic w_load_miss;
    logic w_fetch_miss;
    logic w_done;

    // sdone masks the store that just completed so the core can advance
    // past it in the cycle after the write ack.
    assign w_store_req  = i_dstore && !r_sdone;
    assign w_load_miss  = i_dload && !i_dhit;
    assign w_fetch_miss = i_ifetch && !i_ihit;
    assign w_done       = r_mreq && i_mack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_sdone      <= 1'b0;
            r_mreq       <= 1'b0;
            r_mwe        <= 1'b0;
            r_maddr      <= '0;
            r_mwdata     <= '0;
            r_ifill_wen  <= 1'b0;
            r_ifill_addr <= '0;
            r_ifill_data <= '0;
            r_dfill_wen  <= 1'b0;
            r_dfill_addr <= '0;
            r_dfill_data <= '0;
        end else begin
            r_sdone <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // Data side has priority; a pending fetch miss keeps the
                    // core stalled and is picked up on a later IDLE cycle.
                    if (w_store_req) begin
                        r_state  <= StDwr;
                        r_mreq   <= 1'b1;
                        r_mwe    <= 1'b1;
                        r_maddr  <= i_daddr;
                        r_mwdata <= i_dwdata;
                    end else if (w_load_miss) begin
                        r_state  <= StDrd;
                        r_mreq   <= 1'b1;
                        r_mwe    <= 1'b0;
                        r_maddr  <= i_daddr;
                        r_mwdata <= '0;
                    end else if (w_fetch_miss) begin
                        r_state  <= StIrd;
                        r_mreq   <= 1'b1;
                        r_mwe    <= 1'b0;
                        r_maddr  <= i_iaddr;
                        r_mwdata <= '0;
                    end
                end
                StIrd, StDrd, StDwr: begin
                    if (w_done) begin
                        r_mreq   <= 1'b0;
                        r_mwe    <= 1'b0;
                        r_maddr  <= '0;
                        r_mwdata <= '0;
                        if (r_state == StIrd) begin
                            r_state      <= StIfill;
                            r_ifill_wen  <= 1'b1;
                            r_ifill_addr <= r_maddr;
                            r_ifill_data <= i_mrdata;
                        end else if (r_state == StDrd) begin
                            r_state      <= StDfill;
                            r_dfill_wen  <= 1'b1;
                            r_dfill_addr <= r_maddr;
                            r_dfill_data <= i_mrdata;
                        end else begin
                            r_state <= StIdle;
                            r_sdone <= 1'b1;
                        end
                    end
                end
                StIfill: begin
                    r_ifill_wen <= 1'b0;
                    r_state     <= StIdle;
                end
                StDfill: begin
                    r_dfill_wen <= 1'b0;
                    r_state     <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_stall = (r_state != StIdle) || w_store_req || w_load_miss || w_fetch_miss;

    assign o_mreq       = r_mreq;
    assign o_mwe        = r_mwe;
    assign o_maddr      = r_maddr;
    assign o_mwdata     = r_mwdata;
    assign o_ifill_wen  = r_ifill_wen;
    assign o_ifill_addr = r_ifill_addr;
    assign o_ifill_data = r_ifill_data;
    assign o_dfill_wen  = r_dfill_wen;
    assign o_dfill_addr = r_dfill_addr;
    assign o_dfill_data = r_dfill_data;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cache_refill_ctrl
// Directed bench for cache_refill_ctrl: fetch miss, load miss, store,
// simultaneous data/instruction miss, reset mid-transaction, stray acks.
// ----------------------------------------------------------------------------
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ifetch;
    logic [31:0] i_iaddr;
    logic        i_ihit;
    logic        i_dload;
    logic        i_dstore;
    logic [31:0] i_daddr;
    logic [31:0] i_dwdata;
    logic        i_dhit;
    logic        o_ifill_wen;
    logic [31:0] o_ifill_addr;
    logic [31:0] o_ifill_data;
    logic        o_dfill_wen;
    logic [31:0] o_dfill_addr;
    logic [31:0] o_dfill_data;
    logic        o_stall;
    logic        o_mreq;
    logic        o_mwe;
    logic [31:0] o_maddr;
    logic [31:0] o_mwdata;
    logic        i_mack;
    logic [31:0] i_mrdata;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;
    int txn_base;
    logic [31:0] txn_addr [0:15];

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_ifetch     (i_ifetch),
        .i_iaddr      (i_iaddr),
        .i_ihit       (i_ihit),
        .i_dload      (i_dload),
        .i_dstore     (i_dstore),
        .i_daddr      (i_daddr),
        .i_dwdata     (i_dwdata),
        .i_dhit       (i_dhit),
        .o_ifill_wen  (o_ifill_wen),
        .o_ifill_addr (o_ifill_addr),
        .o_ifill_data (o_ifill_data),
        .o_dfill_wen  (o_dfill_wen),
        .o_dfill_addr (o_dfill_addr),
        .o_dfill_data (o_dfill_data),
        .o_stall      (o_stall),
        .o_mreq       (o_mreq),
        .o_mwe        (o_mwe),
        .o_maddr      (o_maddr),
        .o_mwdata     (o_mwdata),
        .i_mack       (i_mack),
        .i_mrdata     (i_mrdata)
    );

    // Log every completed memory transaction (address, in order).
    always @(posedge clk) begin
        if (!rst && o_mreq && i_mack) begin
            txn_addr[n_txn[3:0]] <= o_maddr;
            n_txn <= n_txn + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_ifetch = 1'b0; i_iaddr = '0; i_ihit = 1'b0;
        i_dload = 1'b0; i_dstore = 1'b0; i_daddr = '0; i_dwdata = '0; i_dhit = 1'b0;
        i_mack = 1'b0; i_mrdata = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".mreq"}, 64'(o_mreq), 64'd0);
        chk({tag, ".ifill_wen"}, 64'(o_ifill_wen), 64'd0);
        chk({tag, ".dfill_wen"}, 64'(o_dfill_wen), 64'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        // Reset state
        chk_quiet("reset");
        chk("reset.mwe", 64'(o_mwe), 64'd0);
        chk("reset.maddr", 64'(o_maddr), 64'd0);
        chk("reset.mwdata", 64'(o_mwdata), 64'd0);
        chk("reset.stall", 64'(o_stall), 64'd0);

        // ---- Fetch miss at 0x100, ack on third request cycle ----
        tick();
        txn_base = n_txn;
        i_ifetch = 1'b1; i_iaddr = 32'h0000_0100; i_ihit = 1'b0;
        #1 chk("fetch.detect_stall", 64'(o_stall), 64'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("fetch.mreq", 64'(o_mreq), 64'd1);
            chk("fetch.mwe", 64'(o_mwe), 64'd0);
            chk("fetch.maddr", 64'(o_maddr), 64'h100);
            chk("fetch.stall", 64'(o_stall), 64'd1);
            chk("fetch.ifill_wen_idle", 64'(o_ifill_wen), 64'd0);
        end
        i_mack = 1'b1; i_mrdata = 32'h0000_0013;
        tick();
        i_mack = 1'b0; i_mrdata = '0;
        chk("fetch.ifill_wen", 64'(o_ifill_wen), 64'd1);
        chk("fetch.ifill_addr", 64'(o_ifill_addr), 64'h100);
        chk("fetch.ifill_data", 64'(o_ifill_data), 64'h13);
        chk("fetch.dfill_wen", 64'(o_dfill_wen), 64'd0);
        chk("fetch.mreq_drop", 64'(o_mreq), 64'd0);
        chk("fetch.fill_stall", 64'(o_stall), 64'd1);
        tick();
        chk("fetch.ifill_wen_end", 64'(o_ifill_wen), 64'd0);
        i_ihit = 1'b1;
        #1 chk("fetch.stall_release", 64'(o_stall), 64'd0);
        chk("fetch.txn_count", 64'(n_txn - txn_base), 64'd1);
        idle_inputs();

        // ---- Load miss at 0x8000_0040, zero-wait ack ----
        tick();
        i_dload = 1'b1; i_daddr = 32'h8000_0040; i_dhit = 1'b0;
        #1 chk("load.stall_c1", 64'(o_stall), 64'd1);
        tick();
        chk("load.mreq", 64'(o_mreq), 64'd1);
        chk("load.mwe", 64'(o_mwe), 64'd0);
        chk("load.maddr", 64'(o_maddr), 64'h8000_0040);
        chk("load.stall_c2", 64'(o_stall), 64'd1);
        i_mack = 1'b1; i_mrdata = 32'hDEAD_BEEF;
        tick();
        i_mack = 1'b0; i_mrdata = '0;
        chk("load.dfill_wen", 64'(o_dfill_wen), 64'd1);
        chk("load.dfill_addr", 64'(o_dfill_addr), 64'h8000_0040);
        chk("load.dfill_data", 64'(o_dfill_data), 64'hDEAD_BEEF);
        chk("load.ifill_wen", 64'(o_ifill_wen), 64'd0);
        chk("load.mreq_drop", 64'(o_mreq), 64'd0);
        chk("load.stall_c3", 64'(o_stall), 64'd1);
        tick();
        i_dhit = 1'b1;
        #1 chk("load.stall_release", 64'(o_stall), 64'd0);
        chk("load.dfill_wen_end", 64'(o_dfill_wen), 64'd0);
        idle_inputs();

        // ---- Store to 0x8000_0044, ack in second request cycle ----
        tick();
        txn_base = n_txn;
        i_dstore = 1'b1; i_daddr = 32'h8000_0044; i_dwdata = 32'h1234_5678;
        #1 chk("store.stall_c1", 64'(o_stall), 64'd1);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("store.mreq", 64'(o_mreq), 64'd1);
            chk("store.mwe", 64'(o_mwe), 64'd1);
            chk("store.maddr", 64'(o_maddr), 64'h8000_0044);
            chk("store.mwdata", 64'(o_mwdata), 64'h1234_5678);
            chk("store.stall", 64'(o_stall), 64'd1);
        end
        i_mack = 1'b1;
        tick();
        i_mack = 1'b0;
        // sdone cycle: store still presented, but stall must be low.
        chk("store.sdone_stall", 64'(o_stall), 64'd0);
        chk_quiet("store.done");
        chk("store.mwe_drop", 64'(o_mwe), 64'd0);
        i_dstore = 1'b0;
        tick();
        chk_quiet("store.after");
        chk("store.txn_count", 64'(n_txn - txn_base), 64'd1);
        idle_inputs();

        // ---- Simultaneous fetch miss 0x200 and load miss 0x8000_0000 ----
        tick();
        txn_base = n_txn;
        i_ifetch = 1'b1; i_iaddr = 32'h0000_0200; i_ihit = 1'b0;
        i_dload = 1'b1; i_daddr = 32'h8000_0000; i_dhit = 1'b0;
        #1 chk("both.stall", 64'(o_stall), 64'd1);
        tick();
        chk("both.first_maddr", 64'(o_maddr), 64'h8000_0000);
        chk("both.first_mreq", 64'(o_mreq), 64'd1);
        i_mack = 1'b1; i_mrdata = 32'hAAAA_0001;
        tick();
        i_mack = 1'b0; i_mrdata = '0;
        chk("both.dfill_wen", 64'(o_dfill_wen), 64'd1);
        chk("both.dfill_data", 64'(o_dfill_data), 64'hAAAA_0001);
        tick();
        i_dhit = 1'b1;
        #1 chk("both.still_stalled", 64'(o_stall), 64'd1);
        tick();
        chk("both.second_maddr", 64'(o_maddr), 64'h200);
        chk("both.second_mreq", 64'(o_mreq), 64'd1);
        i_mack = 1'b1; i_mrdata = 32'h0000_0005;
        tick();
        i_mack = 1'b0; i_mrdata = '0;
        chk("both.ifill_wen", 64'(o_ifill_wen), 64'd1);
        chk("both.ifill_addr", 64'(o_ifill_addr), 64'h200);
        chk("both.ifill_data", 64'(o_ifill_data), 64'h5);
        chk("both.dfill_quiet", 64'(o_dfill_wen), 64'd0);
        tick();
        i_ihit = 1'b1;
        #1 chk("both.stall_release", 64'(o_stall), 64'd0);
        chk("both.txn_count", 64'(n_txn - txn_base), 64'd2);
        chk("both.txn0", 64'(txn_addr[txn_base[3:0]]), 64'h8000_0000);
        chk("both.txn1", 64'(txn_addr[4'(txn_base + 1)]), 64'h200);
        idle_inputs();

        // ---- Reset during IRD with ack pending ----
        tick();
        i_ifetch = 1'b1; i_iaddr = 32'h0000_0300; i_ihit = 1'b0;
        tick();
        chk("rst_ird.mreq", 64'(o_mreq), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_ifetch = 1'b0;
        #1;
        chk_quiet("rst_ird.after");
        chk("rst_ird.maddr", 64'(o_maddr), 64'd0);
        chk("rst_ird.idle_stall", 64'(o_stall), 64'd0);
        tick();
        chk_quiet("rst_ird.next");
        idle_inputs();

        // ---- Stray acks in IDLE ----
        txn_base = n_txn;
        for (int c = 0; c < 3; c++) begin
            i_mack = 1'b1; i_mrdata = 32'hBAD0_0000 + 32'(c);
            tick();
            chk_quiet("stray");
            chk("stray.stall", 64'(o_stall), 64'd0);
        end
        idle_inputs();
        tick();
        chk_quiet("stray.end");
        chk("stray.txn_count", 64'(n_txn - txn_base), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
